// File: rtl/demux1_4_buf_pkg.sv
// Shared types and constants for the 1-to-4 buffered distributor.
// Destination encoding matches the 4:1 source-select mux.
package demux1_4_buf_pkg;

    localparam int WIDTH_DEF = 16;

    typedef logic [1:0] dest_sel_t;

    localparam dest_sel_t DEST0 = 2'd0;
    localparam dest_sel_t DEST1 = 2'd1;
    localparam dest_sel_t DEST2 = 2'd2;
    localparam dest_sel_t DEST3 = 2'd3;

    function automatic logic [3:0] dest_decode(input dest_sel_t s);
        logic [3:0] onehot;
        onehot = 4'b0000;
        case (s)
            DEST0:   onehot = 4'b0001;
            DEST1:   onehot = 4'b0010;
            DEST2:   onehot = 4'b0100;
            default: onehot = 4'b1000;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/demux1_4_buf_sync_fifo.sv
// Single-clock FIFO with a registered head word; full/empty derive from count.
// The head register holds the last word shown once the FIFO drains.
module sync_fifo
    import demux1_4_buf_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0]    cnt_rem, cnt_nxt;
    logic [WIDTH-1:0] head_nxt;
    logic             do_pop, do_push;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        rd_nxt   = do_pop ? rd_ptr + PW'(1) : rd_ptr;
        cnt_rem  = count - CW'(do_pop);
        cnt_nxt  = cnt_rem + CW'(do_push);
        head_nxt = head;
        // Slot at the new read pointer is only being written now if nothing else remains
        if (cnt_nxt != '0) begin
            if (cnt_rem == '0) head_nxt = din;
            else               head_nxt = mem[rd_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_nxt;
            count  <= cnt_nxt;
            head   <= head_nxt;
        end
    end

endmodule

// File: rtl/demux1_4_buf.sv
// Buffered 1-to-4 distributor: steers each accepted word into the FIFO chosen by sel.
// Only the sel decode and the in_ready mux live here.
module demux1_4_buf
    import demux1_4_buf_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    input  dest_sel_t              sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       dout0,
    output logic [WIDTH-1:0]       dout1,
    output logic [WIDTH-1:0]       dout2,
    output logic [WIDTH-1:0]       dout3,
    output logic [3:0]             out_valid,
    input  logic [3:0]             out_ready,
    output logic [$clog2(DEPTH):0] count0,
    output logic [$clog2(DEPTH):0] count1,
    output logic [$clog2(DEPTH):0] count2,
    output logic [$clog2(DEPTH):0] count3
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [3:0]       push_vec, full_vec, empty_vec;
    logic [WIDTH-1:0] head [4];
    logic [CW-1:0]    cnt  [4];

    // A full destination still accepts when its consumer pops in the same cycle
    assign in_ready  = rst_n & ~flush & (~full_vec[sel] | out_ready[sel]);
    assign push_vec  = (in_valid & in_ready) ? dest_decode(sel) : 4'b0000;
    assign out_valid = ~empty_vec;

    for (genvar k = 0; k < 4; k++) begin : g_fifo
        sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .push  (push_vec[k]),
            .pop   (out_ready[k]),
            .din   (din),
            .full  (full_vec[k]),
            .empty (empty_vec[k]),
            .count (cnt[k]),
            .head  (head[k])
        );
    end

    assign dout0  = head[0];
    assign dout1  = head[1];
    assign dout2  = head[2];
    assign dout3  = head[3];
    assign count0 = cnt[0];
    assign count1 = cnt[1];
    assign count2 = cnt[2];
    assign count3 = cnt[3];

endmodule
